// File: rtl/fp_pkg.sv
// Shared constants and types for the sequential FP divider.
// The FP_DIV_ROUND_EN macro selects round-to-nearest-even (one extra quotient bit).
package fp_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned M          = 23;
    localparam int unsigned E          = 8;
    localparam int unsigned BIAS       = 127;
    localparam int unsigned EXP_MAX    = 255;

`ifdef FP_DIV_ROUND_EN
    // Extra bit below the LSB acts as the guard bit
    localparam int unsigned QBITS = M + 3;
`else
    localparam int unsigned QBITS = M + 2;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StIter,
        StNorm,
        StDone
    } fp_div_state_t;

    localparam logic [E-1:0]          EXP_ONES  = '1;
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

    function automatic logic [DATA_WIDTH-1:0] inf_word(input logic sign);
        return {sign, EXP_ONES, {M{1'b0}}};
    endfunction

endpackage

// File: rtl/fp_divider_seq_if.sv
// Operand/result handshake bundle for fp_divider_seq.
interface fp_divider_seq_if;
    import fp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in1;
    logic [DATA_WIDTH-1:0] in2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out;
    logic                  div_by_zero;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, div_by_zero
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, div_by_zero
    );

endinterface

// File: rtl/fp_div_special.sv
// Combinational operand classification: zero detection and special-case result.
module fp_div_special
    import fp_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic                  is_zero1,
    output logic                  is_zero2,
    output logic                  sign,
    output logic [DATA_WIDTH-1:0] special_word
);

    // Zero ignores the sign bit; divisor zero outranks dividend zero
    always_comb begin
        is_zero1     = (in1[DATA_WIDTH-2:0] == '0);
        is_zero2     = (in2[DATA_WIDTH-2:0] == '0);
        sign         = in1[DATA_WIDTH-1] ^ in2[DATA_WIDTH-1];
        special_word = is_zero2 ? inf_word(sign) : ZERO_WORD;
    end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential single-precision divider, radix-2 restoring, one quotient bit per clock.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; default is truncation.
module fp_divider_seq
    import fp_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    fp_divider_seq_if.slave bus
);

    localparam int unsigned RW = M + 3;  // remainder width, headroom for the trial subtract
    localparam logic [4:0]  CNT_LAST = 5'(QBITS - 1);
    localparam logic signed [E+1:0] BIAS_S    = (E+2)'(BIAS);
    localparam logic signed [E+1:0] EXP_MAX_S = (E+2)'(EXP_MAX);
    localparam logic signed [E+1:0] EXP_ZERO  = '0;

    fp_div_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] a_q, b_q, out_q, special_word;
    logic                  dbz_q, sign_q, is_zero1, is_zero2, spec_sign, hs, is_special;
    logic signed [E+1:0]   exp_q, exp_init, exp_adj;
    logic [RW-1:0]         rem_q, rem_cur, rem_next, trial;
    logic [M:0]            div_q, div_cur;
    logic [QBITS-1:0]      q_q;
    logic [4:0]            cnt_q;
    logic                  qbit;
    logic [M-1:0]          mant;
    logic [DATA_WIDTH-1:0] norm_word;
`ifdef FP_DIV_ROUND_EN
    logic [M:0]            mant_r;
    logic                  guard, sticky, rnd;
`endif

    fp_div_special u_special (
        .in1          (bus.in1),
        .in2          (bus.in2),
        .is_zero1     (is_zero1),
        .is_zero2     (is_zero2),
        .sign         (spec_sign),
        .special_word (special_word)
    );

    assign hs         = bus.in_valid && (state_q == StIdle);
    assign is_special = is_zero1 | is_zero2;

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (hs) state_d = is_special ? StDone : StPrep;
            StPrep: state_d = StIter;
            StIter: if (cnt_q == CNT_LAST) state_d = StNorm;
            StNorm: state_d = StDone;
            StDone: if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
    end

    assign bus.out         = out_q;
    assign bus.div_by_zero = dbz_q;

    // One restoring step; PREP feeds the freshly loaded operands so it also yields q[MSB]
    always_comb begin
        rem_cur  = (state_q == StPrep) ? {3'b001, a_q[M-1:0]} : rem_q;
        div_cur  = (state_q == StPrep) ? {1'b1, b_q[M-1:0]} : div_q;
        trial    = rem_cur - {2'b00, div_cur};
        qbit     = ~trial[RW-1];
        rem_next = qbit ? {trial[RW-2:0], 1'b0} : {rem_cur[RW-2:0], 1'b0};
        exp_init = $signed({2'b00, a_q[DATA_WIDTH-2 -: E]})
                 - $signed({2'b00, b_q[DATA_WIDTH-2 -: E]}) + BIAS_S;
    end

    // Normalise the quotient, optionally round, then range-check the exponent
    always_comb begin
        exp_adj = exp_q;
`ifdef FP_DIV_ROUND_EN
        if (q_q[QBITS-1]) begin
            mant   = q_q[QBITS-2:2];
            guard  = q_q[1];
            sticky = q_q[0] | (rem_q != '0);
        end else begin
            mant    = q_q[QBITS-3:1];
            guard   = q_q[0];
            sticky  = (rem_q != '0);
            exp_adj = exp_q - 1;
        end
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{M{1'b0}}, rnd};
        if (mant_r[M]) exp_adj = exp_adj + 1;
        mant = mant_r[M-1:0];
`else
        if (q_q[QBITS-1]) begin
            mant = q_q[QBITS-2:1];
        end else begin
            mant    = q_q[QBITS-3:0];
            exp_adj = exp_q - 1;
        end
`endif
        if (exp_adj >= EXP_MAX_S)     norm_word = inf_word(sign_q);
        else if (exp_adj <= EXP_ZERO) norm_word = ZERO_WORD;
        else                          norm_word = {sign_q, exp_adj[E-1:0], mant};
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            dbz_q  <= 1'b0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (hs) begin
                        a_q   <= bus.in1;
                        b_q   <= bus.in2;
                        dbz_q <= is_zero2;
                        if (is_special) out_q <= special_word;
                    end
                end
                StPrep: begin
                    sign_q <= a_q[DATA_WIDTH-1] ^ b_q[DATA_WIDTH-1];
                    exp_q  <= exp_init;
                    rem_q  <= rem_next;
                    div_q  <= div_cur;
                    q_q    <= {{(QBITS-1){1'b0}}, qbit};
                    cnt_q  <= 5'd1;
                end
                StIter: begin
                    rem_q <= rem_next;
                    q_q   <= {q_q[QBITS-2:0], qbit};
                    cnt_q <= cnt_q + 5'd1;
                end
                StNorm: out_q <= norm_word;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed self-checking bench for fp_divider_seq (honours FP_DIV_ROUND_EN).
module tb_fp_divider_seq;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef FP_DIV_ROUND_EN
    localparam int LAT = 28;
    localparam logic [31:0] ONE_THIRD  = 32'h3EAAAAAB;
    localparam logic [31:0] TWO_THIRDS = 32'h3F2AAAAB;
`else
    localparam int LAT = 27;
    localparam logic [31:0] ONE_THIRD  = 32'h3EAAAAAA;
    localparam logic [31:0] TWO_THIRDS = 32'h3F2AAAAA;
`endif

    fp_divider_seq_if bus ();

    fp_divider_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_out, input logic exp_dbz, input int exp_lat,
                          input bit hold);
        int edges;
        int waits;
        waits = 0;
        while (!bus.in_ready && waits < 100) begin
            @(posedge clk);
            #1 waits++;
        end
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        start_op(a, b);
        edges = 1;
        while (!bus.out_valid && edges < 60) begin
            @(posedge clk);
            #1 edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(exp_lat));
        check({tag, " out"}, bus.out, exp_out);
        check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check({tag, " held out"}, bus.out, exp_out);
                check({tag, " held out_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, " held div_by_zero"}, 32'(bus.div_by_zero), 32'(exp_dbz));
                check({tag, " held in_ready"}, 32'(bus.in_ready), 32'd0);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        check({tag, " release out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " release in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        #1 rst_n = 1'b0;
        #11;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out", bus.out, 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("6/2 bp",     32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT, 1'b1);
        run_op("1/3",        32'h3F800000, 32'h40400000, ONE_THIRD,    1'b0, LAT, 1'b0);
        run_op("2/3",        32'h40000000, 32'h40400000, TWO_THIRDS,   1'b0, LAT, 1'b0);
        run_op("-8/0.5",     32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, LAT, 1'b0);
        run_op("1/0",        32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1,   1'b0);
        run_op("-1/+0",      32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1,   1'b0);
        run_op("0/2",        32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1,   1'b0);
        run_op("overflow",   32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0, LAT, 1'b0);
        run_op("underflow",  32'h00800000, 32'h40000000, 32'h00000000, 1'b0, LAT, 1'b0);

        // Abort mid-iteration with an asynchronous reset between clock edges
        start_op(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out", bus.out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("-8/0.5 post-reset", 32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0, LAT, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
